pulse_sync_hs: RTL and testbench
================================

Name: pulse_sync_hs

Overview:
- Parametrised successor to the strobe-qualified data-capture synchronizer.
- An asynchronous strobe `stb` passes through a configurable-depth flop chain. A mode-selected event detector turns it into capture events, and each event loads `data_in` into a held output register.
- Adds over the previous generation:
  - a one-cycle `valid` pulse and a toggle `ack` for the source-side handshake;
  - a guard window with sticky overrun detection;
  - a capture counter.
- Sits between the registered input pins and downstream logic.

Parameters:
- N, 8, data width (≥1).
- SYNC_STAGES, 2, depth of the strobe synchronizer chain (≥2).
- MODE, 1, event mode: 0 = LEVEL, 1 = RISE, 2 = TOGGLE. Any other value is a static elaboration error.
- GUARD_CYC, 4, number of enabled cycles after a capture during which new events are rejected (0 = no guard). Ignored in LEVEL mode.
- CW, 8, width of the capture counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; all state advances only when high
- stb  in  1  asynchronous strobe from source
- data_in  in  N  data, stable at source while `stb` is asserted
- clr_ovr  in  1  clears the overrun flag
- data_out  out  N  held captured data
- valid  out  1  one-cycle pulse on each capture
- ack  out  1  toggles on each capture (level handshake back to source)
- busy  out  1  high while in GUARD state
- overrun  out  1  sticky: event rejected during guard
- cap_cnt  out  CW  number of captures, wraps modulo 2^CW

Behaviour:
- Reset is sampled at posedge `clk`; `rst_n`=0 forces the following to 0:
  - sync chain, prev, `data_out`, `valid`, `ack`, `busy`, `overrun`, `cap_cnt`;
  - FSM goes to IDLE.
  - Reset has priority over `ena`. Reset mid-guard aborts to IDLE.
- Sync chain: `sync[0]<=stb`, `sync[i]<=sync[i-1]`. `s = sync[SYNC_STAGES-1]`, `prev <= s`.
- Event (combinational), by mode:
  - LEVEL: `s`.
  - RISE: `s & ~prev`.
  - TOGGLE: `s ^ prev`.
- Latency: if `stb` is first sampled high at edge E0, the capture happens at edge E(SYNC_STAGES) and `data_out` takes `data_in` as sampled at that edge. `valid` is high for exactly the cycle following that edge.
- If `stb` is high when `rst_n` is released, RISE and TOGGLE both generate one event, because the chain resets to 0.
- FSM states IDLE and GUARD. Guard counter width is clog2(GUARD_CYC+1).
- IDLE + event → capture:
  - `data_out<=data_in`, `valid<=1`, `ack<=~ack`, `cap_cnt<=cap_cnt+1`.
  - If GUARD_CYC>0 and MODE≠LEVEL, go to GUARD with counter=GUARD_CYC.
- GUARD: counter decrements each enabled cycle; return to IDLE on the cycle the counter reaches 0. This gives exactly GUARD_CYC cycles in GUARD.
  - An event in GUARD causes no capture and sets `overrun<=1`; `data_out` and `cap_cnt` are unchanged.
- LEVEL mode: captures every enabled cycle while `s`=1, so `data_out` tracks `data_in` delayed by one cycle. `valid` stays high; `ack` toggles every capture. GUARD is never entered and `busy` stays 0.
- `busy` = (state==GUARD), registered.
- `overrun`:
  - cleared by `clr_ovr`;
  - if a set and a clear occur in the same cycle, set wins.
- `ena`=0: the sync chain, prev, FSM, counters, `data_out`, `ack`, and `overrun` all hold. `valid<=0`, so a pulse is never stretched. `clr_ovr` is ignored.
- `cap_cnt` wraps from 2^CW-1 to 0 without any flag.

Decomposition:
- Package `pulse_sync_pkg` holds:
  - MODE_LEVEL=0, MODE_RISE=1, MODE_TOGGLE=2;
  - the FSM state encoding (IDLE=0, GUARD=1).
- Sub-module `sync_chain` (params SYNC_STAGES, WIDTH=1; ports clk, rst_n, ena, d, q). It is the reset-to-0 flop chain and is reused for other asynchronous inputs.

Test Plan:
- N=8, S=2, RISE, GUARD=4, `data_in`=8'hA5, `stb` raised at E0 and held 10 cycles → `data_out`=8'hA5 at E2; `valid`=1 for one cycle; `ack` 0→1; `cap_cnt`=1; no further capture while `stb` stays high.
- RISE, second `stb` rising edge whose event lands 2 cycles after a capture → no capture; `overrun`=1; `busy`=1 for 4 cycles. Assert `clr_ovr` in the same cycle as a new rejected event → `overrun` remains 1; a lone `clr_ovr` → 0.
- TOGGLE, `stb` 0→1 then 1→0 spaced 8 cycles apart with `data_in` 8'h11 then 8'h22 → two captures (8'h11, then 8'h22); `ack` returns to 0; `cap_cnt`=2.
- LEVEL, `stb` high for 3 synced cycles with `data_in` 8'h01, 8'h02, 8'h03 → `data_out` follows each value one cycle later; `valid` high for 3 cycles; `busy` never asserted.
- Events with `ena` toggled low mid-guard → guard counter freezes, `valid` goes to 0, and the guard duration extends by exactly the number of disabled cycles. `rst_n`=0 mid-guard → all outputs 0 at the next edge.
- CW=2, 5 RISE captures → `cap_cnt` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Purpose: shared constants and types for the strobe-qualified capture synchronizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_sync_pkg;

    // Event detector modes selected by the MODE parameter.
    localparam int MODE_LEVEL  = 0;
    localparam int MODE_RISE   = 1;
    localparam int MODE_TOGGLE = 2;

    // Capture FSM encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    // Width of the guard down-counter.
    // The counter must hold GUARD_CYC itself. It is kept at least one bit
    // wide so that the no-guard build still has a legal vector.
    function automatic int guard_cnt_width(input int guard_cyc);
        return (guard_cyc > 0) ? $clog2(guard_cyc + 1) : 1;
    endfunction

    // True for the three legal event modes.
    function automatic bit mode_is_legal(input int mode);
        return (mode == MODE_LEVEL) || (mode == MODE_RISE) || (mode == MODE_TOGGLE);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Purpose: reset-to-zero flop chain that brings asynchronous inputs into the clk domain.
// Latency: SYNC_STAGES enabled cycles from d to q.
// Backpressure: none; the chain freezes while ena is low.
module sync_chain
    import pulse_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 is the metastability-exposed flop; the last stage is the only one read.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    // Shift the input through the chain on every enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else if (ena) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_sync_hs.sv
// Purpose: synchronize an async strobe, turn it into capture events and latch data_in with valid/ack handshake.
// Latency: capture at the SYNC_STAGES-th edge after stb is first sampled high; valid/data_out one cycle later.
// Backpressure: none; events arriving during the guard window are dropped and flagged in sticky overrun.
module pulse_sync_hs
    import pulse_sync_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 1,
    parameter int GUARD_CYC   = 4,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          stb,
    input  logic [N-1:0]  data_in,
    input  logic          clr_ovr,
    output logic [N-1:0]  data_out,
    output logic          valid,
    output logic          ack,
    output logic          busy,
    output logic          overrun,
    output logic [CW-1:0] cap_cnt
);

    localparam int            GW         = guard_cnt_width(GUARD_CYC);
    localparam bit            USE_GUARD  = (GUARD_CYC > 0) && (MODE != MODE_LEVEL);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC);

    // Reject unsupported configurations at elaboration time.
    generate
        if (!mode_is_legal(MODE)) begin : g_bad_mode
            $error("pulse_sync_hs: MODE must be 0 (LEVEL), 1 (RISE) or 2 (TOGGLE)");
        end
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("pulse_sync_hs: SYNC_STAGES must be at least 2");
        end
        if (N < 1) begin : g_bad_width
            $error("pulse_sync_hs: N must be at least 1");
        end
    endgenerate

    logic          w_s;
    logic          w_event;
    logic          w_reject;
    logic          r_prev;
    state_t        r_state;
    logic [GW-1:0] r_gcnt;
    logic [N-1:0]  r_data;
    logic          r_valid;
    logic          r_ack;
    logic          r_busy;
    logic          r_ovr;
    logic [CW-1:0] r_cap_cnt;

    // Strobe synchronizer. The chain resets to 0, so a strobe already high
    // at reset release looks like a fresh edge to the RISE and TOGGLE detectors.
    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     (stb),
        .q     (w_s)
    );

    // Mode-selected event detector on the synchronized strobe.
    always_comb begin
        w_event = 1'b0;
        case (MODE)
            MODE_LEVEL: w_event = w_s;
            MODE_RISE:  w_event = w_s & ~r_prev;
            default:    w_event = w_s ^ r_prev;
        endcase
    end

    // An event seen while the guard window is open is dropped.
    assign w_reject = w_event && (r_state == ST_GUARD);

    // Capture FSM. All outputs are registered here.
    // While disabled, everything holds except valid, which is cleared so a
    // pulse never lasts longer than one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev    <= 1'b0;
            r_state   <= ST_IDLE;
            r_gcnt    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_cap_cnt <= '0;
        end else if (ena) begin
            r_prev  <= w_s;
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        r_data    <= data_in;
                        r_valid   <= 1'b1;
                        r_ack     <= ~r_ack;
                        r_cap_cnt <= r_cap_cnt + CW'(1);
                        if (USE_GUARD) begin
                            r_state <= ST_GUARD;
                            r_gcnt  <= GUARD_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_GUARD: begin
                    // Leaving on the step that takes the counter to zero
                    // gives exactly GUARD_CYC enabled cycles in GUARD.
                    if (r_gcnt <= GW'(1)) begin
                        r_state <= ST_IDLE;
                        r_gcnt  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt - GW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gcnt  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end else begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun flag. A rejection in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (ena) begin
            if (w_reject) begin
                r_ovr <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;
    assign ack      = r_ack;
    assign busy     = r_busy;
    assign overrun  = r_ovr;
    assign cap_cnt  = r_cap_cnt;

endmodule

// File: tb/tb_pulse_sync_hs.sv
// Purpose: directed self-checking bench for pulse_sync_hs in RISE, TOGGLE, LEVEL and narrow-counter builds.
// Latency: all checks sampled 1 ns after the active edge.
// Backpressure: n/a.
module tb_pulse_sync_hs;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       stb;
    logic [7:0] data_in;
    logic       clr_ovr;

    logic [7:0] ru_dout, tg_dout, lv_dout, c2_dout;
    logic       ru_valid, tg_valid, lv_valid, c2_valid;
    logic       ru_ack, tg_ack, lv_ack, c2_ack;
    logic       ru_busy, tg_busy, lv_busy, c2_busy;
    logic       ru_ovr, tg_ovr, lv_ovr, c2_ovr;
    logic [7:0] ru_cnt, tg_cnt, lv_cnt;
    logic [1:0] c2_cnt;

    int n_run  = 0;
    int n_fail = 0;

    pulse_sync_hs #(.N(8), .SYNC_STAGES(2), .MODE(1), .GUARD_CYC(4), .CW(8)) u_rise (
        .clk(clk), .rst_n(rst_n), .ena(ena), .stb(stb), .data_in(data_in), .clr_ovr(clr_ovr),
        .data_out(ru_dout), .valid(ru_valid), .ack(ru_ack), .busy(ru_busy), .overrun(ru_ovr), .cap_cnt(ru_cnt));

    pulse_sync_hs #(.N(8), .SYNC_STAGES(2), .MODE(2), .GUARD_CYC(4), .CW(8)) u_tog (
        .clk(clk), .rst_n(rst_n), .ena(ena), .stb(stb), .data_in(data_in), .clr_ovr(clr_ovr),
        .data_out(tg_dout), .valid(tg_valid), .ack(tg_ack), .busy(tg_busy), .overrun(tg_ovr), .cap_cnt(tg_cnt));

    pulse_sync_hs #(.N(8), .SYNC_STAGES(2), .MODE(0), .GUARD_CYC(4), .CW(8)) u_lvl (
        .clk(clk), .rst_n(rst_n), .ena(ena), .stb(stb), .data_in(data_in), .clr_ovr(clr_ovr),
        .data_out(lv_dout), .valid(lv_valid), .ack(lv_ack), .busy(lv_busy), .overrun(lv_ovr), .cap_cnt(lv_cnt));

    pulse_sync_hs #(.N(8), .SYNC_STAGES(2), .MODE(1), .GUARD_CYC(4), .CW(2)) u_cw2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .stb(stb), .data_in(data_in), .clr_ovr(clr_ovr),
        .data_out(c2_dout), .valid(c2_valid), .ack(c2_ack), .busy(c2_busy), .overrun(c2_ovr), .cap_cnt(c2_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ena     = 1'b1;
        stb     = 1'b0;
        clr_ovr = 1'b0;
        data_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ena     = 1'b1;
        stb     = 1'b0;
        clr_ovr = 1'b0;
        data_in = 8'hFF;
        tick();
        tick();
        n_run++; if ({ru_dout, ru_valid, ru_ack, ru_busy, ru_ovr, ru_cnt} !== 20'h0) begin n_fail++; $display("FAIL reset_rise: got %h expected 0", {ru_dout, ru_valid, ru_ack, ru_busy, ru_ovr, ru_cnt}); end
        n_run++; if ({tg_dout, tg_valid, tg_ack, tg_busy, tg_ovr, tg_cnt} !== 20'h0) begin n_fail++; $display("FAIL reset_toggle: got %h expected 0", {tg_dout, tg_valid, tg_ack, tg_busy, tg_ovr, tg_cnt}); end
        n_run++; if ({c2_dout, c2_valid, c2_ack, c2_busy, c2_ovr, c2_cnt} !== 14'h0) begin n_fail++; $display("FAIL reset_cw2: got %h expected 0", {c2_dout, c2_valid, c2_ack, c2_busy, c2_ovr, c2_cnt}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rise();
        int bcnt;
        int vcnt;
        do_reset();
        data_in = 8'hA5;
        stb     = 1'b1;
        tick();
        tick();
        n_run++; if (ru_valid !== 1'b0) begin n_fail++; $display("FAIL rise_early_valid: got %b expected 0", ru_valid); end
        tick();
        n_run++; if (ru_dout !== 8'hA5) begin n_fail++; $display("FAIL rise_data: got %h expected a5", ru_dout); end
        n_run++; if (ru_valid !== 1'b1) begin n_fail++; $display("FAIL rise_valid: got %b expected 1", ru_valid); end
        n_run++; if (ru_ack !== 1'b1) begin n_fail++; $display("FAIL rise_ack: got %b expected 1", ru_ack); end
        n_run++; if (ru_cnt !== 8'd1) begin n_fail++; $display("FAIL rise_cnt: got %0d expected 1", ru_cnt); end
        bcnt = int'(ru_busy);
        vcnt = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            bcnt += int'(ru_busy);
            vcnt += int'(ru_valid);
        end
        n_run++; if (vcnt !== 0) begin n_fail++; $display("FAIL rise_valid_pulse: extra valid cycles %0d expected 0", vcnt); end
        n_run++; if (ru_cnt !== 8'd1) begin n_fail++; $display("FAIL rise_held_cnt: got %0d expected 1", ru_cnt); end
        n_run++; if (bcnt !== 4) begin n_fail++; $display("FAIL rise_busy_len: got %0d expected 4", bcnt); end
        stb = 1'b0;
    endtask

    task automatic test_overrun();
        int bcnt;
        do_reset();
        data_in = 8'hA5;
        stb = 1'b1; tick();
        stb = 1'b0; tick();
        stb = 1'b1; tick();
        n_run++; if (ru_dout !== 8'hA5) begin n_fail++; $display("FAIL ovr_first_data: got %h expected a5", ru_dout); end
        bcnt = int'(ru_busy);
        data_in = 8'h5A;
        tick();
        bcnt += int'(ru_busy);
        n_run++; if (ru_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b expected 0", ru_ovr); end
        tick();
        bcnt += int'(ru_busy);
        n_run++; if (ru_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ru_ovr); end
        n_run++; if (ru_dout !== 8'hA5) begin n_fail++; $display("FAIL ovr_data_held: got %h expected a5", ru_dout); end
        n_run++; if (ru_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_cnt_held: got %0d expected 1", ru_cnt); end
        for (int i = 0; i < 5; i++) begin
            tick();
            bcnt += int'(ru_busy);
        end
        n_run++; if (bcnt !== 4) begin n_fail++; $display("FAIL ovr_busy_len: got %0d expected 4", bcnt); end
        stb = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        stb = 1'b1; tick();
        stb = 1'b0; tick();
        stb = 1'b1; tick();
        n_run++; if (ru_cnt !== 8'd2) begin n_fail++; $display("FAIL ovr_second_cnt: got %0d expected 2", ru_cnt); end
        n_run++; if (ru_dout !== 8'h5A) begin n_fail++; $display("FAIL ovr_second_data: got %h expected 5a", ru_dout); end
        tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        n_run++; if (ru_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b expected 1", ru_ovr); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        n_run++; if (ru_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", ru_ovr); end
        stb = 1'b0;
    endtask

    task automatic test_reset_mid_guard();
        do_reset();
        data_in = 8'h3C;
        stb = 1'b1; tick();
        stb = 1'b0; tick();
        stb = 1'b1; tick();
        tick();
        tick();
        n_run++; if ({ru_busy, ru_ovr} !== 2'b11) begin n_fail++; $display("FAIL midguard_pre: busy,ovr got %b expected 11", {ru_busy, ru_ovr}); end
        rst_n = 1'b0;
        tick();
        n_run++; if ({ru_dout, ru_valid, ru_ack, ru_busy, ru_ovr, ru_cnt} !== 20'h0) begin n_fail++; $display("FAIL midguard_reset: got %h expected 0", {ru_dout, ru_valid, ru_ack, ru_busy, ru_ovr, ru_cnt}); end
        rst_n = 1'b1;
        stb   = 1'b0;
    endtask

    task automatic test_rst_release();
        rst_n = 1'b0;
        stb   = 1'b1;
        data_in = 8'h77;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        n_run++; if ({ru_valid, ru_cnt} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL release_rise: valid,cnt got %h expected 101", {ru_valid, ru_cnt}); end
        n_run++; if ({tg_valid, tg_cnt} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL release_toggle: valid,cnt got %h expected 101", {tg_valid, tg_cnt}); end
        stb = 1'b0;
    endtask

    task automatic test_toggle();
        do_reset();
        data_in = 8'h11;
        stb = 1'b1;
        tick(); tick(); tick();
        n_run++; if ({tg_dout, tg_ack, tg_cnt} !== {8'h11, 1'b1, 8'd1}) begin n_fail++; $display("FAIL toggle_first: got %h expected 111_1_01", {tg_dout, tg_ack, tg_cnt}); end
        for (int i = 0; i < 5; i++) tick();
        data_in = 8'h22;
        stb = 1'b0;
        tick(); tick(); tick();
        n_run++; if (tg_dout !== 8'h22) begin n_fail++; $display("FAIL toggle_second_data: got %h expected 22", tg_dout); end
        n_run++; if (tg_ack !== 1'b0) begin n_fail++; $display("FAIL toggle_ack_back: got %b expected 0", tg_ack); end
        n_run++; if (tg_cnt !== 8'd2) begin n_fail++; $display("FAIL toggle_cnt: got %0d expected 2", tg_cnt); end
        n_run++; if (tg_valid !== 1'b1) begin n_fail++; $display("FAIL toggle_valid: got %b expected 1", tg_valid); end
    endtask

    task automatic test_level();
        logic busy_seen;
        do_reset();
        busy_seen = 1'b0;
        data_in = 8'h00;
        stb = 1'b1;
        tick();
        tick();
        busy_seen |= lv_busy;
        data_in = 8'h01;
        tick();
        busy_seen |= lv_busy;
        n_run++; if ({lv_dout, lv_valid, lv_ack} !== {8'h01, 1'b1, 1'b1}) begin n_fail++; $display("FAIL level_c1: got %h expected 01_1_1", {lv_dout, lv_valid, lv_ack}); end
        stb = 1'b0;
        data_in = 8'h02;
        tick();
        busy_seen |= lv_busy;
        n_run++; if ({lv_dout, lv_valid, lv_ack} !== {8'h02, 1'b1, 1'b0}) begin n_fail++; $display("FAIL level_c2: got %h expected 02_1_0", {lv_dout, lv_valid, lv_ack}); end
        data_in = 8'h03;
        tick();
        busy_seen |= lv_busy;
        n_run++; if ({lv_dout, lv_valid, lv_ack} !== {8'h03, 1'b1, 1'b1}) begin n_fail++; $display("FAIL level_c3: got %h expected 03_1_1", {lv_dout, lv_valid, lv_ack}); end
        data_in = 8'h04;
        tick();
        busy_seen |= lv_busy;
        n_run++; if ({lv_dout, lv_valid} !== {8'h03, 1'b0}) begin n_fail++; $display("FAIL level_end: got %h expected 03_0", {lv_dout, lv_valid}); end
        n_run++; if (lv_cnt !== 8'd3) begin n_fail++; $display("FAIL level_cnt: got %0d expected 3", lv_cnt); end
        n_run++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL level_busy: got %b expected 0", busy_seen); end
    endtask

    task automatic test_ena_guard();
        int bcnt;
        do_reset();
        data_in = 8'hC3;
        stb = 1'b1;
        tick(); tick(); tick();
        n_run++; if ({ru_dout, ru_busy} !== {8'hC3, 1'b1}) begin n_fail++; $display("FAIL ena_capture: got %h expected c3_1", {ru_dout, ru_busy}); end
        bcnt = int'(ru_busy);
        for (int i = 0; i < 12; i++) begin
            ena = (i >= 1 && i < 4) ? 1'b0 : 1'b1;
            tick();
            bcnt += int'(ru_busy);
            if (i == 0) begin
                n_run++; if (lv_valid !== 1'b1) begin n_fail++; $display("FAIL ena_level_on: valid got %b expected 1", lv_valid); end
            end
            if (i == 1) begin
                n_run++; if (lv_valid !== 1'b0) begin n_fail++; $display("FAIL ena_valid_drop: valid got %b expected 0", lv_valid); end
            end
        end
        ena = 1'b1;
        n_run++; if (bcnt !== 7) begin n_fail++; $display("FAIL ena_busy_len: got %0d expected 7", bcnt); end
        n_run++; if (ru_cnt !== 8'd1) begin n_fail++; $display("FAIL ena_cnt: got %0d expected 1", ru_cnt); end
        stb = 1'b0;
    endtask

    task automatic test_cw_wrap();
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            data_in = 8'(k + 8'h40);
            stb = 1'b1;
            tick(); tick(); tick();
            n_run++; if ({c2_valid, c2_cnt} !== {1'b1, 2'(exp_seq[k])}) begin n_fail++; $display("FAIL cw2_cnt[%0d]: valid,cnt got %b expected 1,%0d", k, {c2_valid, c2_cnt}, exp_seq[k]); end
            stb = 1'b0;
            for (int j = 0; j < 6; j++) tick();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        stb     = 1'b0;
        clr_ovr = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_rise();
        test_overrun();
        test_reset_mid_guard();
        test_rst_release();
        test_toggle();
        test_level();
        test_ena_guard();
        test_cw_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
